// File: rtl/debounce_pkg.sv
// Shared types and helpers for the time-shared button debounce scheduler.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_rr_pick.sv
// Combinational round-robin picker: first pending channel at or after rr_ptr, wrapping.
module debounce_rr_pick
  import debounce_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int ID_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0] pending,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] idx;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_CH);
      if (!grant_valid && pending[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// One debounce counter time-shared across N_CH synchronized buttons; commits
// the settled level and emits one-cycle rise/fall pulses per channel.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int ID_W           = clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig_sync,
  input  logic [N_CH-1:0] sig_change,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            busy,
  output logic [ID_W-1:0] active_id
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_CH - 1);

  state_t          state;
  logic [CNT_W-1:0] counter;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] pending_next;
  logic [N_CH-1:0] set_mask;
  logic [N_CH-1:0] clr_mask;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic            grant_valid;
  logic            init_done;

  debounce_rr_pick #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_pick (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // An edge on the channel being counted restarts its count instead of queueing;
  // an edge coinciding with its own grant is absorbed by that grant.
  always_comb begin
    set_mask = sig_change;
    clr_mask = '0;
    if (state == S_COUNT) set_mask[active_id] = 1'b0;
    if (state == S_IDLE && grant_valid) clr_mask[grant_id] = 1'b1;
    pending_next = (pending | set_mask) & ~clr_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      counter    <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      init_done  <= 1'b0;
      stable     <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      busy       <= 1'b0;
      active_id  <= '0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;

      // The first edge after reset queues every channel so held buttons resolve.
      if (!init_done) begin
        init_done <= 1'b1;
        pending   <= '1;
      end else begin
        pending <= pending_next;
      end

      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            active_id <= grant_id;
            counter   <= '0;
            state     <= S_COUNT;
            busy      <= 1'b1;
          end
        end

        S_COUNT: begin
          if (sig_change[active_id]) begin
            counter <= '0;
          end else if (counter == TERMINAL) begin
            state <= S_COMMIT;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        S_COMMIT: begin
          if (sig_sync[active_id] != stable[active_id]) begin
            stable[active_id] <= sig_sync[active_id];
            if (sig_sync[active_id]) rise_pulse[active_id] <= 1'b1;
            else                     fall_pulse[active_id] <= 1'b1;
          end
          rr_ptr <= (active_id == LAST_ID) ? '0 : active_id + ID_W'(1);
          state  <= S_IDLE;
          busy   <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_CH=4, DEBOUNCE_CYCLES=4.
module tb_debounce_scheduler;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int D     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sig_sync = '0;
  logic [3:0] sig_change = '0;
  logic [3:0] stable;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       busy;
  logic [1:0] active_id;

  int n_vec = 0;
  int n_bad = 0;

  debounce_scheduler #(
    .N_CH            (N_CH),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_sync   (sig_sync),
    .sig_change (sig_change),
    .stable     (stable),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .active_id  (active_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sync;
    logic [3:0] chg;
    int         wait_cyc;
    logic [3:0] stable;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[19];

  // Observed fields packed as {busy, active_id, stable, rise, fall}.
  function automatic logic [14:0] observed();
    return {busy, active_id, stable, rise_pulse, fall_pulse};
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: busy/id/stable/rise/fall got %b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
               name, got[14], got[13:12], got[11:8], got[7:4], got[3:0],
               exp[14], exp[13:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and follows the 4-channel init sweep, each channel
  // committing lvl[k] at edge 7+6k with an idle cycle between services.
  task automatic sweep(input logic [3:0] lvl, input string tag);
    logic       exp_busy;
    logic [1:0] exp_id;
    logic [3:0] exp_stable;
    logic [3:0] exp_rise;
    int         slot;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      step();
      exp_busy   = (e >= 2) && (e <= 25) && (((e - 2) % 6) != 5);
      slot       = (e < 2) ? 0 : (e - 2) / 6;
      exp_id     = (slot > 3) ? 2'd3 : 2'(slot);
      exp_stable = '0;
      exp_rise   = '0;
      for (int k = 0; k < 4; k++) begin
        if (e >= 7 + 6 * k) exp_stable[k] = lvl[k];
        if (e == 7 + 6 * k) exp_rise[k]   = lvl[k];
      end
      check($sformatf("%s_e%0d", tag, e), observed(),
            {exp_busy, exp_id, exp_stable, exp_rise, 4'b0000});
    end
  endtask

  initial begin
    // Rows continue one timeline from the idle state after the first sweep.
    vecs[0]  = '{4'b0100, 4'b0100, 2, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
    vecs[1]  = '{4'b0100, 4'b0000, 4, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2};
    vecs[2]  = '{4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2};
    vecs[3]  = '{4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2};
    vecs[4]  = '{4'b0000, 4'b0100, 6, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2};
    vecs[5]  = '{4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd2};
    vecs[6]  = '{4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2};
    vecs[7]  = '{4'b0010, 4'b0010, 3, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1};
    vecs[8]  = '{4'b0000, 4'b0010, 2, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1};
    vecs[9]  = '{4'b0010, 4'b0010, 5, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1};
    vecs[10] = '{4'b0010, 4'b0000, 1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd1};
    vecs[11] = '{4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1};
    vecs[12] = '{4'b0011, 4'b0001, 2, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd0};
    vecs[13] = '{4'b0010, 4'b0001, 5, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd0};
    vecs[14] = '{4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[15] = '{4'b1011, 4'b1001, 2, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd3};
    vecs[16] = '{4'b1011, 4'b0000, 5, 4'b1010, 4'b1000, 4'b0000, 1'b0, 2'd3};
    vecs[17] = '{4'b1011, 4'b0000, 6, 4'b1011, 4'b0001, 4'b0000, 1'b0, 2'd0};
    vecs[18] = '{4'b1011, 4'b0000, 1, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0};

    // Reset state, then the init sweep with every button released.
    step();
    step();
    step();
    check("reset_state", observed(), 15'b0);
    sweep(4'b0000, "sweep0");

    // Isolated edges, bounce restarts, glitch, and round-robin order.
    for (int i = 0; i < 19; i++) begin
      sig_sync   = vecs[i].sync;
      sig_change = vecs[i].chg;
      step();
      sig_change = '0;
      for (int w = 1; w < vecs[i].wait_cyc; w++) step();
      check($sformatf("row%0d", i), observed(),
            {vecs[i].busy, vecs[i].id, vecs[i].stable, vecs[i].rise, vecs[i].fall});
    end

    // Reset asserted mid-count on ch2 clears outputs without a clock edge.
    sig_sync   = 4'b1111;
    sig_change = 4'b0100;
    step();
    sig_change = '0;
    step();
    step();
    check("midcount_ch2", observed(), {1'b1, 2'd2, 4'b1011, 4'b0000, 4'b0000});
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), 15'b0);
    sweep(4'b1111, "sweep1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
